// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the divider and its multiplier companion:
// FSM state type, field widths, bias and canonical constant encodings.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int Q_W    = MANT_W + 1;
  localparam int CNT_W  = 5;

  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_NORM,
    ST_DONE
  } state_e;

  function automatic logic [31:0] fp32_pack(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp32_mant_divider.sv
// Restoring mantissa divider: one quotient bit per clock, MSB first,
// Q_W iterations after a start pulse.
module fp32_mant_divider
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic [Q_W-1:0]    q,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Q_W - 1);

  logic [Q_W-1:0]    rem_q, rem_d, rem_sub;
  logic [Q_W-1:0]    q_q, q_d;
  logic [MANT_W-1:0] divisor_q;
  logic [CNT_W-1:0]  count_q;
  logic              busy_q;
  logic              take;

  always_comb begin
    take    = rem_q >= {1'b0, divisor_q};
    rem_sub = take ? (rem_q - {1'b0, divisor_q}) : rem_q;
    // After a restoring step rem < divisor < 2^24, so the shift never overflows.
    rem_d   = {rem_sub[Q_W-2:0], 1'b0};
    q_d     = {q_q[Q_W-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else if (start) begin
      rem_q     <= {1'b0, mant_a};
      q_q       <= '0;
      divisor_q <= mant_b;
      count_q   <= '0;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      rem_q   <= rem_d;
      q_q     <= q_d;
      count_q <= count_q + 1'b1;
      if (count_q == LAST_CNT) busy_q <= 1'b0;
    end
  end

  // High during the final iteration; q holds the full quotient on the next cycle.
  assign done = busy_q && (count_q == LAST_CNT);
  assign q    = q_q;

endmodule

// File: rtl/fp32_div_iter.sv
// Iterative FP32 divider with valid/ready on both sides: truncating,
// denormals flushed to zero, special operands resolved without iterating.
module fp32_div_iter
  import fp32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient
);

  state_e             state_q;
  logic               in_ready_q, out_valid_q, sign_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [EXP_W-1:0]   ea_q, eb_q;

  logic [EXP_W-1:0]   a_exp, b_exp;
  logic               a_zero, b_zero, a_inf, b_inf, special, sign_in;
  logic [31:0]        special_res, norm_res;
  logic               div_start, div_done;
  logic [Q_W-1:0]     div_q;
  logic signed [9:0]  e_norm;
  logic [FRAC_W-1:0]  mant_norm;

  always_comb begin
    a_exp   = a[30:23];
    b_exp   = b[30:23];
    a_zero  = a_exp == '0;
    b_zero  = b_exp == '0;
    a_inf   = a_exp == EXP_W'(FP32_EXP_MAX);
    b_inf   = b_exp == EXP_W'(FP32_EXP_MAX);
    special = a_zero | b_zero | a_inf | b_inf;
    sign_in = a[31] ^ b[31];

    if (a_inf || b_inf || (a_zero && b_zero))
      special_res = FP32_QNAN;
    else if (a_zero)
      special_res = fp32_pack(sign_in, '0, '0);
    else
      special_res = fp32_pack(sign_in, '1, '0);
  end

  always_comb begin
    mant_norm = div_q[Q_W-1] ? div_q[Q_W-2:1] : div_q[Q_W-3:0];
    e_norm    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
              + (div_q[Q_W-1] ? 10'(FP32_BIAS) : 10'(FP32_BIAS - 1));
    if (e_norm >= $signed(10'(FP32_EXP_MAX)))
      norm_res = fp32_pack(sign_q, '1, '0);
    else if (e_norm <= 10'sd0)
      norm_res = fp32_pack(sign_q, '0, '0);
    else
      norm_res = fp32_pack(sign_q, e_norm[EXP_W-1:0], mant_norm);
  end

  assign div_start = (state_q == ST_IDLE) && in_valid && !special;

  fp32_mant_divider u_mant_div (
    .clk    (clk),
    .rst    (rst),
    .start  (div_start),
    .mant_a ({1'b1, a[FRAC_W-1:0]}),
    .mant_b ({1'b1, b[FRAC_W-1:0]}),
    .q      (div_q),
    .done   (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q     <= sign_in;
            ea_q       <= a_exp;
            eb_q       <= b_exp;
            in_ready_q <= 1'b0;
            if (special) begin
              quotient_q  <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (div_done) state_q <= ST_NORM;
        end
        ST_NORM: begin
          quotient_q  <= norm_res;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;

endmodule

// File: tb/tb_fp32_div_iter.sv
// Directed bench for fp32_div_iter: hand-computed quotients, latency,
// backpressure and mid-operation reset.
module tb_fp32_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;

  int checks = 0;
  int errors = 0;

  fp32_div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-24s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, {31'b0, in_ready}, 32'd1);
  endtask

  // Presents a/b, counts edges from the accepting edge (inclusive) until out_valid.
  task automatic start_and_wait(input logic [31:0] ta, input logic [31:0] tb_v,
                                input int exp_edges, input string tag);
    int n;
    wait_ready(tag);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] texp,
                        input int exp_edges, input string tag);
    start_and_wait(ta, tb_v, exp_edges, tag);
    check({tag, "_q"}, quotient, texp);
    finish_op(tag);
  endtask

  initial begin
    int stale;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_quotient", quotient, 32'h0);

    // Normal operands: 25 CALC + 1 NORM edges after the accept edge.
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 27, "six_div_two");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, "one_div_three");
    run_op(32'hC1000000, 32'h3F000000, 32'hC1800000, 27, "m8_div_half");

    // Special operands resolve on the accepting edge.
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, "one_div_zero");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1, "zero_div_zero");
    run_op(32'h80000000, 32'h3F800000, 32'h80000000, 1, "negzero_div_one");
    run_op(32'h7F800000, 32'h3F800000, 32'h7FC00000, 1, "inf_div_one");

    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 27, "overflow");
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 27, "underflow");

    // Backpressure: hold the result, ignore new operands meanwhile.
    start_and_wait(32'h3F800000, 32'h40400000, 27, "bp");
    check("bp_q", quotient, 32'h3EAAAAAA);
    for (int i = 0; i < 5; i++) begin
      a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_hold_q", quotient, 32'h3EAAAAAA);
      check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    finish_op("bp");
    @(posedge clk); #1;
    check("bp_ignored_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_ignored_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset during CALC aborts the operation.
    wait_ready("rst");
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_quotient", quotient, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    stale = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst_no_stale_valid", 32'(stale), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 27, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
